md_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the Execute stage of the 5-stage MIPS pipeline.
- Consumes the rs/rt operand values and the decoded mult/div operation that the decode-to-execute pipeline register presents in E.
- Owns the architectural HI/LO registers and drives `busy` to the hazard unit so that later mult/div/mfhi/mflo instructions stall in D.

---
 rtl/md_unit.sv | 161 ++++++++++++++++
 tb/tb_md_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the Execute stage; owns HI/LO and stalls later md ops via busy.
// Define MD_UNIT_MADD_EN to add MADD/MADDU/MSUB/MSUBU (ops 8-11) accumulating into {hi,lo}.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd8;
   localparam logic [3:0] OP_MADDU = 4'd9;
   localparam logic [3:0] OP_MSUB  = 4'd10;
   localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e        state;
   logic [CW-1:0] count;
   logic [63:0]   result;

   logic          is_mul;
   logic          is_div;
   logic          is_signed;
`ifdef MD_UNIT_MADD_EN
   logic          is_acc;
   logic          is_sub;
`endif

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      is_mul    = 1'b0;
      is_div    = 1'b0;
      is_signed = 1'b0;
`ifdef MD_UNIT_MADD_EN
      is_acc    = 1'b0;
      is_sub    = 1'b0;
`endif
      case (op)
         OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
         OP_MULTU: is_mul = 1'b1;
         OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
         OP_DIVU:  is_div = 1'b1;
`ifdef MD_UNIT_MADD_EN
         OP_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; end
         OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
         OP_MSUB:  begin is_mul = 1'b1; is_signed = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
         OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
         default: ;
      endcase
   end

   // Sign- or zero-extend to 64 bits; the truncated 64x64 product is exact for both cases.
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] product;
   logic [63:0] acc;

   assign mul_a   = {{32{is_signed & rs[31]}}, rs};
   assign mul_b   = {{32{is_signed & rt[31]}}, rt};
   assign product = mul_a * mul_b;
   assign acc     = {hi, lo};

   // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow corner.
   logic        a_neg;
   logic        b_neg;
   logic        div_zero;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] mag_b_nz;
   logic [31:0] uquot;
   logic [31:0] urem;
   logic [31:0] quot;
   logic [31:0] rem;

   assign a_neg    = is_signed & rs[31];
   assign b_neg    = is_signed & rt[31];
   assign mag_a    = a_neg ? -rs : rs;
   assign mag_b    = b_neg ? -rt : rt;
   assign div_zero = (rt == 32'd0);
   assign mag_b_nz = div_zero ? 32'd1 : mag_b;
   assign uquot    = mag_a / mag_b_nz;
   assign urem     = mag_a % mag_b_nz;
   assign quot     = (a_neg ^ b_neg) ? -uquot : uquot;
   assign rem      = a_neg ? -urem : urem;

   logic [63:0] result_next;

   always_comb begin
      result_next = product;
      if (is_div) begin
         result_next = div_zero ? acc : {rem, quot};
      end
`ifdef MD_UNIT_MADD_EN
      else if (is_acc) begin
         result_next = is_sub ? (acc - product) : (acc + product);
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         count  <= '0;
         result <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (is_mul || is_div) begin
                     result <= result_next;
                     count  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                     busy   <= 1'b1;
                     state  <= S_RUN;
                  end else if (op == OP_MTHI) begin
                     hi <= rs;
                  end else if (op == OP_MTLO) begin
                     lo <= rs;
                  end
               end
            end
            S_RUN: begin
               // start is ignored here: the hazard unit stalls md ops while busy.
               if (count == CW'(1)) begin
                  {hi, lo} <= result;
                  count    <= '0;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  count <= count - CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios with literal expectations plus a random run
// checked every cycle against a cycle-stamped behavioural model of HI/LO and busy.
module tb_md_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .rs    (rs),
      .rt    (rt),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result of an accepted op; returns 0 when the op never makes the unit busy.
   function automatic bit ref_calc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [63:0] accum, output logic [63:0] res, output int lat);
      longint sa;
      longint sb;
      longint q;
      longint r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = accum;
      lat = 0;
      ref_calc = 1'b1;
      case (o)
         4'd1: begin res = sa * sb; lat = MC; end
         4'd2: begin res = {32'd0, a} * {32'd0, b}; lat = MC; end
         4'd3: begin
            lat = DC;
            if (b != 0) begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         4'd4: begin
            lat = DC;
            if (b != 0) res = {a % b, a / b};
         end
`ifdef MD_UNIT_MADD_EN
         4'd8:  begin res = accum + 64'(sa * sb); lat = MC; end
         4'd9:  begin res = accum + {32'd0, a} * {32'd0, b}; lat = MC; end
         4'd10: begin res = accum - 64'(sa * sb); lat = MC; end
         4'd11: begin res = accum - {32'd0, a} * {32'd0, b}; lat = MC; end
`endif
         default: ref_calc = 1'b0;
      endcase
   endfunction

   // Model: an accepted op is stamped with the edge number at which its result lands.
   bit [31:0] m_hi = '0;
   bit [31:0] m_lo = '0;
   bit        m_busy = 1'b0;
   bit [63:0] m_pend;
   int        cyc = 0;
   int        m_done_at = 0;

   always @(posedge clk or posedge reset) begin
      logic [63:0] r;
      int          lat;
      if (reset) begin
         m_hi   = '0;
         m_lo   = '0;
         m_busy = 1'b0;
         cyc    = 0;
      end else begin
         cyc++;
         if (m_busy) begin
            if (cyc == m_done_at) begin
               {m_hi, m_lo} = m_pend;
               m_busy = 1'b0;
            end
         end else if (start) begin
            if (op == 4'd5) m_hi = rs;
            else if (op == 4'd6) m_lo = rs;
            else if (ref_calc(op, rs, rt, {m_hi, m_lo}, r, lat)) begin
               m_pend    = r;
               m_done_at = cyc + lat;
               m_busy    = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_busy", 32'(busy), 32'(m_busy));
         check("model_hi", hi, m_hi);
         check("model_lo", lo, m_lo);
      end
   end

   task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      rs    = a;
      rt    = b;
      @(negedge clk);
      start = 1'b0;
      op    = 4'd0;
   endtask

   task automatic count_busy(input string name, input int exp);
      int n = 0;
      while (busy && n < 64) begin
         n++;
         @(negedge clk);
      end
      check(name, 32'(n), 32'(exp));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 64 && busy; i++) @(negedge clk);
      check("wait_idle", 32'(busy), 32'd0);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom % 8)
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 4'd0;
      rs    = '0;
      rt    = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      reset  = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      do_op(4'd1, 32'hFFFF_FFFD, 32'd5);
      count_busy("mult_busy_cycles", 5);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFF1);

      do_op(4'd4, 32'd100, 32'd7);
      count_busy("divu_busy_cycles", 10);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);

      do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle();
      check("div_neg_lo", lo, 32'hFFFF_FFFD);
      check("div_neg_hi", hi, 32'hFFFF_FFFF);

      do_op(4'd5, 32'h1234_5678, 32'd0);
      check("mthi_busy", 32'(busy), 32'd0);
      check("mthi_hi", hi, 32'h1234_5678);
      do_op(4'd3, 32'd5, 32'd0);
      count_busy("div0_busy_cycles", 10);
      check("div0_hi", hi, 32'h1234_5678);
      check("div0_lo", lo, 32'hFFFF_FFFD);

      do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (2) @(negedge clk);
      do_op(4'd6, 32'hAA, 32'd0);
      wait_idle();
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'd0);

      do_op(4'd7, 32'h55, 32'h66);
      check("reserved_busy", 32'(busy), 32'd0);
      check("reserved_lo", lo, 32'h8000_0000);
      do_op(4'd0, 32'h55, 32'h66);
      check("none_busy", 32'(busy), 32'd0);

      do_op(4'd3, 32'd100, 32'd3);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      check("abort_hi_after", hi, 32'd0);
      check("abort_lo_after", lo, 32'd0);

      do_op(4'd5, 32'd0, 32'd0);
      do_op(4'd6, 32'h10, 32'd0);
      do_op(4'd8, 32'hFFFF_FFFF, 32'd4);
`ifdef MD_UNIT_MADD_EN
      count_busy("madd_busy_cycles", 5);
      check("madd_hi", hi, 32'd0);
      check("madd_lo", lo, 32'h0000_000C);
`else
      check("madd_off_busy", 32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      check("madd_off_hi", hi, 32'd0);
      check("madd_off_lo", lo, 32'h0000_0010);
`endif

      for (int i = 0; i < 1500; i++) begin
         start = ($urandom % 3) == 0;
         op    = 4'($urandom % 16);
         rs    = pick_val();
         rt    = pick_val();
         @(negedge clk);
      end
      start = 1'b0;
      op    = 4'd0;
      wait_idle();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
